pipe_hazard_ctrl: RTL and testbench
===================================

// Module: pipe_hazard_ctrl
// PURPOSE
//  Pipeline sequencer for the 5-stage RV64 core. Generates enable/clear controls for PC, IF/ID, ID/EX and EX/MEM.
//  Inserts load-use bubbles, flushes on EX-stage redirects and freezes the pipe while data memory is busy.
//  A watchdog bounds the memory wait. Sits beside the hazard/forwarding logic. Drives the enable-capable ID/EX register variant.
// PARAMETERS
//  REG_AW       5    register index width
//  MEM_TIMEOUT  256  max MEM_WAIT cycles before forced release (>=2)
//  PERF_W       32   perf counter width (HAZARD_PERF_CNT_EN only)
// PORTS
//  clk              in   1      core clock, rising edge
//  reset_n          in   1      asynchronous, active-low reset
//  id_rs1,id_rs2    in   REG_AW source regs of instr in ID
//  id_use_rs1/rs2   in   1      instr in ID reads rs1/rs2
//  idex_rd          in   REG_AW dest reg of instr in EX
//  idex_memread     in   1      instr in EX is a load
//  ex_redirect      in   1      taken branch / jal / jalr resolved in EX
//  exmem_mem_req    in   1      instr in MEM accesses dmem
//  dmem_ack         in   1      dmem completes access this cycle
//  err_clr          in   1      clears timeout_err
//  pc_en            out  1      PC register load enable
//  ifid_en/ifid_clr out  1      IF/ID hold-when-0 / synchronous bubble
//  idex_en/idex_clr out  1      ID/EX hold-when-0 / synchronous bubble
//  exmem_en         out  1      EX/MEM load enable
//  stall            out  1      1 when any stage is held this cycle
//  timeout_err      out  1      sticky: MEM_WAIT watchdog expired
// BEHAVIOUR
//  Clock and reset: one clock, clk. reset_n is asynchronous and active-low.
//  Outputs: all outputs except timeout_err and the perf counters are combinational from state and inputs.
//  States: INIT, RUN, MEM_WAIT. Reset forces state=INIT, wait_cnt=0 and timeout_err=0.
//  INIT (held during reset and 1 cycle after release):
//   - pc_en=0, ifid_en=1, ifid_clr=1, idex_en=1, idex_clr=1, exmem_en=0, stall=1.
//   - INIT->RUN unconditionally.
//  Derived terms:
//   - load_use = idex_memread & (idex_rd!=0) & ((id_use_rs1 & id_rs1==idex_rd) | (id_use_rs2 & id_rs2==idex_rd)).
//   - mem_busy = exmem_mem_req & ~dmem_ack.
//  RUN, priority mem_busy > ex_redirect > load_use > normal:
//   - mem_busy: all enables 0, clears 0, stall=1. Next state MEM_WAIT, wait_cnt=1.
//   - ex_redirect: all enables 1, ifid_clr=1, idex_clr=1. A simultaneous load_use is ignored because the ID instr is squashed.
//   - load_use: pc_en=0, ifid_en=0, idex_en=1, idex_clr=1, exmem_en=1, stall=1. One bubble per occurrence.
//   - normal: all enables 1, clears 0, stall=0.
//  MEM_WAIT:
//   - Cycle with dmem_ack=0 and wait_cnt<MEM_TIMEOUT: full freeze as above, wait_cnt++.
//   - dmem_ack=1: outputs equal RUN outputs with mem_busy=0, so a pending redirect or load_use applies in the same cycle.
//     Next state RUN, wait_cnt=0.
//   - wait_cnt==MEM_TIMEOUT and dmem_ack=0: release as if acked. timeout_err sets on the next edge. Next state RUN.
//  timeout_err:
//   - Stays set until err_clr=1. err_clr is ignored on a cycle that sets timeout_err; set wins.
//   - wait_cnt width is $clog2(MEM_TIMEOUT+1) and never wraps.
//  Freeze latency: zero. Controls act on the edge ending the cycle in which the condition is seen.
//  Reset mid-MEM_WAIT: state returns to INIT, the pipe is flushed and the outstanding dmem access is abandoned.
// CONFIGURATION
//  HAZARD_PERF_CNT_EN defined:
//   - Adds outputs perf_stall_cyc[PERF_W] (cycles with stall=1 in RUN/MEM_WAIT) and perf_flush_cnt[PERF_W] (ex_redirect flush cycles).
//   - Both counters saturate at all-ones and reset to 0.
//  HAZARD_PERF_CNT_EN undefined: those ports and counters do not exist. Control behaviour is identical.
// TESTING
//  T1: idex_memread=1, idex_rd=5, id_rs1=5, id_use_rs1=1 in RUN
//      -> single cycle pc_en=0, ifid_en=0, idex_clr=1; next cycle normal.
//  T2: same as T1 with idex_rd=0, or id_use_rs1=0 -> no stall, all enables 1.
//  T3: ex_redirect=1 together with a T1 load_use -> ifid_clr=1, idex_clr=1, pc_en=1, stall=0.
//  T4: exmem_mem_req=1 with dmem_ack low 3 cycles, then high
//      -> 3 frozen cycles (all enables 0); ack cycle all enables 1; state RUN.
//  T5: MEM_TIMEOUT=4, dmem_ack never asserts
//      -> release after the 4th wait cycle; timeout_err=1 until err_clr; err_clr with a new expiry keeps it 1.
//  T6: reset_n low mid-MEM_WAIT -> async INIT outputs immediately; one INIT cycle after release, then RUN;
//      with HAZARD_PERF_CNT_EN, counters read 0.

Source files
------------

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline sequencer for the 5-stage RV64 core: load-use bubbles, redirect flushes, dmem freeze with watchdog.
// Optional perf counters are enabled by defining HAZARD_PERF_CNT_EN.
module pipe_hazard_ctrl #(
    parameter int REG_AW      = 5,
    parameter int MEM_TIMEOUT = 256,
    parameter int PERF_W      = 32
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic              id_use_rs1,
    input  logic              id_use_rs2,
    input  logic [REG_AW-1:0] idex_rd,
    input  logic              idex_memread,
    input  logic              ex_redirect,
    input  logic              exmem_mem_req,
    input  logic              dmem_ack,
    input  logic              err_clr,
    output logic              pc_en,
    output logic              ifid_en,
    output logic              ifid_clr,
    output logic              idex_en,
    output logic              idex_clr,
    output logic              exmem_en,
    output logic              stall,
`ifdef HAZARD_PERF_CNT_EN
    output logic [PERF_W-1:0] perf_stall_cyc,
    output logic [PERF_W-1:0] perf_flush_cnt,
`endif
    output logic              timeout_err
);

    localparam int CNT_W = $clog2(MEM_TIMEOUT + 1);

    typedef enum logic [1:0] {
        INIT,
        RUN,
        MEM_WAIT
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic             timeout_err_q, timeout_err_d;
    logic             load_use, mem_busy, release_run;

    assign load_use = idex_memread && (idex_rd != '0) &&
                      ((id_use_rs1 && (id_rs1 == idex_rd)) || (id_use_rs2 && (id_rs2 == idex_rd)));
    assign mem_busy = exmem_mem_req && !dmem_ack;

    always_comb begin
        state_d       = state_q;
        wait_cnt_d    = wait_cnt_q;
        timeout_err_d = err_clr ? 1'b0 : timeout_err_q;
        release_run   = 1'b0;
        pc_en         = 1'b0;
        ifid_en       = 1'b0;
        ifid_clr      = 1'b0;
        idex_en       = 1'b0;
        idex_clr      = 1'b0;
        exmem_en      = 1'b0;
        stall         = 1'b1;

        case (state_q)
            INIT: begin
                ifid_en    = 1'b1;
                ifid_clr   = 1'b1;
                idex_en    = 1'b1;
                idex_clr   = 1'b1;
                state_d    = RUN;
                wait_cnt_d = '0;
            end
            RUN: begin
                if (mem_busy) begin
                    state_d    = MEM_WAIT;
                    wait_cnt_d = CNT_W'(1);
                end else begin
                    release_run = 1'b1;
                end
            end
            MEM_WAIT: begin
                if (dmem_ack) begin
                    release_run = 1'b1;
                    state_d     = RUN;
                    wait_cnt_d  = '0;
                end else if (wait_cnt_q < CNT_W'(MEM_TIMEOUT)) begin
                    wait_cnt_d = wait_cnt_q + CNT_W'(1);
                end else begin
                    // Watchdog expiry: release as if acked; set beats a same-cycle err_clr
                    release_run   = 1'b1;
                    state_d       = RUN;
                    wait_cnt_d    = '0;
                    timeout_err_d = 1'b1;
                end
            end
            default: begin
                state_d    = INIT;
                wait_cnt_d = '0;
            end
        endcase

        // Redirect squashes the ID instruction, so it outranks load-use
        if (release_run) begin
            if (ex_redirect) begin
                pc_en    = 1'b1;
                ifid_en  = 1'b1;
                ifid_clr = 1'b1;
                idex_en  = 1'b1;
                idex_clr = 1'b1;
                exmem_en = 1'b1;
                stall    = 1'b0;
            end else if (load_use) begin
                idex_en  = 1'b1;
                idex_clr = 1'b1;
                exmem_en = 1'b1;
            end else begin
                pc_en    = 1'b1;
                ifid_en  = 1'b1;
                idex_en  = 1'b1;
                exmem_en = 1'b1;
                stall    = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= INIT;
            wait_cnt_q    <= '0;
            timeout_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            wait_cnt_q    <= wait_cnt_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    assign timeout_err = timeout_err_q;

`ifdef HAZARD_PERF_CNT_EN
    function automatic logic [PERF_W-1:0] sat_inc(input logic [PERF_W-1:0] v, input logic en);
        if (en && (v != '1)) return v + PERF_W'(1);
        return v;
    endfunction

    logic [PERF_W-1:0] stall_cyc_q, stall_cyc_d;
    logic [PERF_W-1:0] flush_cnt_q, flush_cnt_d;

    always_comb begin
        stall_cyc_d = sat_inc(stall_cyc_q, stall && (state_q != INIT));
        flush_cnt_d = sat_inc(flush_cnt_q, release_run && ex_redirect);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stall_cyc_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            stall_cyc_q <= stall_cyc_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign perf_stall_cyc = stall_cyc_q;
    assign perf_flush_cnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl: expected control vectors are queued when stimulus is applied
// and compared on the following falling edge.
module tb_pipe_hazard_ctrl;

    localparam int REG_AW = 5;
    localparam int PERF_W = 32;

    // {pc_en, ifid_en, ifid_clr, idex_en, idex_clr, exmem_en, stall}
    localparam logic [6:0] INIT_O = 7'b0111101;
    localparam logic [6:0] FRZ_O  = 7'b0000001;
    localparam logic [6:0] RED_O  = 7'b1111110;
    localparam logic [6:0] LU_O   = 7'b0001111;
    localparam logic [6:0] NRM_O  = 7'b1101010;

    logic clk = 1'b0;
    logic reset_n;
    logic [REG_AW-1:0] id_rs1, id_rs2, idex_rd;
    logic id_use_rs1, id_use_rs2, idex_memread, ex_redirect, exmem_mem_req, dmem_ack, err_clr;
    logic pc_en, ifid_en, ifid_clr, idex_en, idex_clr, exmem_en, stall, timeout_err;
`ifdef HAZARD_PERF_CNT_EN
    logic [PERF_W-1:0] perf_stall_cyc, perf_flush_cnt;
`endif

    pipe_hazard_ctrl #(.REG_AW(REG_AW), .MEM_TIMEOUT(4), .PERF_W(PERF_W)) dut (
        .clk(clk), .reset_n(reset_n),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
        .idex_rd(idex_rd), .idex_memread(idex_memread), .ex_redirect(ex_redirect),
        .exmem_mem_req(exmem_mem_req), .dmem_ack(dmem_ack), .err_clr(err_clr),
        .pc_en(pc_en), .ifid_en(ifid_en), .ifid_clr(ifid_clr), .idex_en(idex_en),
        .idex_clr(idex_clr), .exmem_en(exmem_en), .stall(stall),
`ifdef HAZARD_PERF_CNT_EN
        .perf_stall_cyc(perf_stall_cyc), .perf_flush_cnt(perf_flush_cnt),
`endif
        .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic rstn;
        logic [REG_AW-1:0] rs1, rs2, rd;
        logic u1, u2, mr, red, req, ack, clr;
    } stim_t;

    stim_t s;
    logic [7:0] exp_q[$];
    string      tag_q[$];
    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic apply();
        reset_n       = s.rstn;
        id_rs1        = s.rs1;
        id_rs2        = s.rs2;
        idex_rd       = s.rd;
        id_use_rs1    = s.u1;
        id_use_rs2    = s.u2;
        idex_memread  = s.mr;
        ex_redirect   = s.red;
        exmem_mem_req = s.req;
        dmem_ack      = s.ack;
        err_clr       = s.clr;
    endtask

    task automatic idle(input logic rstn);
        s = '{rstn: rstn, rs1: '0, rs2: '0, rd: '0, u1: 1'b0, u2: 1'b0,
              mr: 1'b0, red: 1'b0, req: 1'b0, ack: 1'b0, clr: 1'b0};
    endtask

    task automatic cyc(input string tag, input logic [6:0] ctl, input logic err);
        @(posedge clk);
        #1;
        apply();
        exp_q.push_back({ctl, err});
        tag_q.push_back(tag);
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            logic [7:0] e;
            string t;
            e = exp_q.pop_front();
            t = tag_q.pop_front();
            chk(t, {24'd0, pc_en, ifid_en, ifid_clr, idex_en, idex_clr, exmem_en, stall, timeout_err},
                {24'd0, e});
        end
    end

    task automatic load_use_t1();
        s.mr = 1'b1; s.rd = 5'd5; s.rs1 = 5'd5; s.u1 = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "bench timeout");
    end

    initial begin
        idle(1'b0);
        apply();
        cyc("rst0", INIT_O, 1'b0);
        cyc("rst1", INIT_O, 1'b0);
        idle(1'b1);
        cyc("init_cycle", INIT_O, 1'b0);
        cyc("run_idle", NRM_O, 1'b0);

        // T1 / T2: load-use detection
        load_use_t1();                                  cyc("t1_lu", LU_O, 1'b0);
        idle(1'b1);                                     cyc("t1_next", NRM_O, 1'b0);
        load_use_t1(); s.rd = 5'd0; s.rs1 = 5'd0;       cyc("t2_rd0", NRM_O, 1'b0);
        load_use_t1(); s.u1 = 1'b0;                     cyc("t2_nouse", NRM_O, 1'b0);
        idle(1'b1); s.mr = 1'b1; s.rd = 5'd5; s.rs2 = 5'd5; s.u2 = 1'b1;
        cyc("t2_rs2", LU_O, 1'b0);
        idle(1'b1); load_use_t1(); s.rs1 = 5'd6;        cyc("t2_miss", NRM_O, 1'b0);
        load_use_t1(); s.mr = 1'b0;                     cyc("t2_noload", NRM_O, 1'b0);

        // T3: redirect overrides load-use
        load_use_t1(); s.red = 1'b1;                    cyc("t3_redir", RED_O, 1'b0);

        // T4: dmem wait of 3 cycles then ack
        idle(1'b1); s.req = 1'b1;
        cyc("t4_f1", FRZ_O, 1'b0);
        cyc("t4_f2", FRZ_O, 1'b0);
        cyc("t4_f3", FRZ_O, 1'b0);
        s.ack = 1'b1;                                   cyc("t4_ack", NRM_O, 1'b0);
        idle(1'b1);                                     cyc("t4_run", NRM_O, 1'b0);
        s.req = 1'b1;                                   cyc("t4b_f", FRZ_O, 1'b0);
        s.ack = 1'b1; s.red = 1'b1;                     cyc("t4b_redir", RED_O, 1'b0);
        idle(1'b1); s.req = 1'b1;                       cyc("t4c_f", FRZ_O, 1'b0);
        s.ack = 1'b1; load_use_t1();                    cyc("t4c_lu", LU_O, 1'b0);
        idle(1'b1);                                     cyc("t4c_run", NRM_O, 1'b0);

        // T5: watchdog expiry with MEM_TIMEOUT=4
        s.req = 1'b1;
        for (int i = 0; i < 4; i++) cyc("t5_wait", FRZ_O, 1'b0);
        cyc("t5_release", NRM_O, 1'b0);
        cyc("t5_err_set", FRZ_O, 1'b1);
        s.ack = 1'b1;                                   cyc("t5_ack", NRM_O, 1'b1);
        idle(1'b1); s.clr = 1'b1;                       cyc("t5_clr", NRM_O, 1'b1);
        s.clr = 1'b0;                                   cyc("t5_cleared", NRM_O, 1'b0);
        s.req = 1'b1;
        for (int i = 0; i < 4; i++) cyc("t5b_wait", FRZ_O, 1'b0);
        s.clr = 1'b1;                                   cyc("t5b_release", NRM_O, 1'b0);
        s.clr = 1'b0;                                   cyc("t5b_set_wins", FRZ_O, 1'b1);
        cyc("t5b_wait2", FRZ_O, 1'b1);

        // T6: reset in the middle of a memory wait
        idle(1'b0); s.req = 1'b1;                       cyc("t6_rst", INIT_O, 1'b0);
        cyc("t6_rst_hold", INIT_O, 1'b0);
        idle(1'b1);                                     cyc("t6_init", INIT_O, 1'b0);
        cyc("t6_run", NRM_O, 1'b0);

        @(negedge clk);
        #1;
        chk("drain", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
